// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART receive path.
//   UART_DATA_W        data byte width delivered by the receiver
//   UART_RXFIFO_DEPTH  default depth of the receive buffer
//   ERR_CNT_W          width of the saturating framing-error counter
//   sat_inc()          saturating increment for the error counter
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_RXFIFO_DEPTH = 16;
    localparam int ERR_CNT_W         = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        logic [ERR_CNT_W-1:0] result;
        if (value == ERR_CNT_MAX) begin
            result = value;
        end else begin
            result = value + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with registered read port.
//   clk, reset_n    clock and synchronous active-low reset
//   push, wr_data   write request and data (accepted unless full without a pop)
//   pop             read request (ignored when empty)
//   rd_data         registered read data, holds between pops
//   rd_valid        one-cycle pulse, rd_data is fresh this cycle
//   count           occupancy; empty/full derived from it
//   push_drop       a push was refused this cycle because the FIFO was full
// DEPTH must be a power of two >= 2 so the pointers wrap by plain overflow.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             push_drop
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic             push_drop_s;

    // Accept decisions; a pop frees a slot in the same cycle, so a full FIFO still takes a push when popped.
    always_comb begin
        pop_ok_s    = 1'b0;
        push_ok_s   = 1'b0;
        push_drop_s = 1'b0;
        if (pop && (count_r != {CNT_W{1'b0}})) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && ((count_r != FULL_CNT) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        push_drop_s = push & ~push_ok_s;
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            rd_data_r  <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= pop_ok_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                // Nonblocking read returns the old entry even when a full-FIFO push hits the same slot.
                rd_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign count     = count_r;
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == FULL_CNT);
    assign push_drop = push_drop_s;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the host.
//   clk, reset_n        clock and synchronous active-low reset
//   rx_data, rx_done    receiver byte and done level (one push per rising edge)
//   rx_error            receiver stop-bit error level (one event per rising edge)
//   rd_en               host pop request
//   rd_data, rd_valid   registered popped byte and its one-cycle valid pulse
//   empty, full, count  occupancy status
//   overflow, clr_ovf   sticky dropped-byte flag and its clear (set wins)
//   frame_err_cnt       saturating framing-error event count
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RXFIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_done,
    input  logic                     rx_error,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [ERR_CNT_W-1:0]     frame_err_cnt
);

    logic                 rx_done_q_r;
    logic                 rx_error_q_r;
    logic                 overflow_r;
    logic [ERR_CNT_W-1:0] frame_err_cnt_r;
    logic                 push_s;
    logic                 err_evt_s;
    logic                 drop_s;

    // Rising-edge detect: rx_done may be held for a whole baud tick but must push only once.
    always_comb begin
        push_s    = rx_done & ~rx_done_q_r;
        err_evt_s = rx_error & ~rx_error_q_r;
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .wr_data   (rx_data),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .push_drop (drop_s)
    );

    // Edge-detect history, sticky overflow and framing-error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_done_q_r     <= 1'b0;
            rx_error_q_r    <= 1'b0;
            overflow_r      <= 1'b0;
            frame_err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else begin
            rx_done_q_r  <= rx_done;
            rx_error_q_r <= rx_error;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
            if (err_evt_s) begin
                frame_err_cnt_r <= sat_inc(frame_err_cnt_r);
            end
        end
    end

    assign overflow      = overflow_r;
    assign frame_err_cnt = frame_err_cnt_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model,
// per-cycle comparison, directed scenarios plus randomized traffic.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic [WIDTH-1:0] rx_data  = 8'h00;
    logic             rx_done  = 1'b0;
    logic             rx_error = 1'b0;
    logic             rd_en    = 1'b0;
    logic             clr_ovf  = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [4:0]       count;
    logic             overflow;
    logic [7:0]       frame_err_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_error      (rx_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    logic [7:0] m_rd_data   = 8'h00;
    bit         m_rd_valid  = 1'b0;
    bit         m_ovf       = 1'b0;
    int         m_err       = 0;
    bit         m_prev_done = 1'b0;
    bit         m_prev_err  = 1'b0;
    bit         m_push, m_pop, m_drop;

    // Model update on each active edge from the inputs that the DUT sees.
    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_rd_data   = 8'h00;
            m_rd_valid  = 1'b0;
            m_ovf       = 1'b0;
            m_err       = 0;
            m_prev_done = 1'b0;
            m_prev_err  = 1'b0;
        end else begin
            m_push = rx_done && !m_prev_done;
            m_pop  = rd_en && (mq.size() > 0);
            m_drop = 1'b0;
            m_rd_valid = m_pop;
            if (m_pop) m_rd_data = mq.pop_front();
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(rx_data);
                else m_drop = 1'b1;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (rx_error && !m_prev_err && m_err < 255) m_err++;
            m_prev_done = rx_done;
            m_prev_err  = rx_error;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("rd_data", 32'(rd_data), 32'(m_rd_data));
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit d, input logic [7:0] data, input bit e, input bit rd, input bit clr);
        rx_done  = d;
        rx_data  = data;
        rx_error = e;
        rd_en    = rd;
        clr_ovf  = clr;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        cyc(1'b1, b, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    bit         r_done;
    bit         r_err;
    int         thresh;
    logic [7:0] b8;

    initial begin
        // Reset state
        reset_n = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_err", 32'(frame_err_cnt), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;

        // Single byte with long rx_done
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("single_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("single_rd_valid", 32'(rd_valid), 32'd1);
        chk("single_rd_data", 32'(rd_data), 32'hA5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_pulse_end", 32'(rd_valid), 32'd0);

        // Pop when empty
        for (int i = 0; i < 3; i++) begin
            pop_one();
            chk("empty_pop_valid", 32'(rd_valid), 32'd0);
            chk("empty_pop_count", 32'(count), 32'd0);
            chk("empty_pop_data_hold", 32'(rd_data), 32'hA5);
        end

        // Fill and overflow
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        push_byte(8'hFF);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop_one();
            chk("fill_pop_data", 32'(rd_data), 32'(i));
            chk("fill_pop_valid", 32'(rd_valid), 32'd1);
        end
        chk("fill_drained", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Simultaneous push and pop when full
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("pp_full_data", 32'(rd_data), 32'h20);
        chk("pp_full_count", 32'(count), 32'd16);
        chk("pp_full_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            pop_one();
            if (i < 15) chk("pp_drain_data", 32'(rd_data), 32'h21 + 32'(i));
        end
        chk("pp_last_55", 32'(rd_data), 32'h55);

        // Overflow set wins over clear
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        cyc(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear2", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) pop_one();
        chk("ovf_drain_last", 32'(rd_data), 32'h4F);

        // Framing errors and saturation
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("err_cnt3", 32'(frame_err_cnt), 32'd3);
        chk("err_count_unchanged", 32'(count), 32'd0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("err_saturate", 32'(frame_err_cnt), 32'd255);
        chk("err_count_unchanged2", 32'(count), 32'd0);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'h80 + 8'(i), 1'b0, (i % 3) == 0, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, (i % 2) == 0, 1'b0);
        end
        while (!empty) pop_one();

        // Randomized traffic, pop rate varies by phase so the FIFO fills and drains
        r_done = 1'b0;
        r_err  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            thresh = (i / 300) % 4;
            if ($urandom_range(0, 2) == 0) r_done = ~r_done;
            if ($urandom_range(0, 15) == 0) r_err = ~r_err;
            b8 = 8'($urandom_range(0, 255));
            cyc(r_done, b8, r_err, $urandom_range(0, 3) < thresh, $urandom_range(0, 19) == 0);
        end

        // Reset mid-operation
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        while (!empty) pop_one();
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        chk("pre_reset_count", 32'(count), 32'd5);
        reset_n = 1'b0;
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("midreset_count", 32'(count), 32'd0);
        chk("midreset_empty", 32'(empty), 32'd1);
        chk("midreset_err", 32'(frame_err_cnt), 32'd0);
        chk("midreset_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_reset_push", 32'(count), 32'd1);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_reset_single", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("post_reset_data", 32'(rd_data), 32'h77);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed byte from the receiver's `rx_data`/`rx_done` outputs into a synchronous FIFO and lets the host side pop bytes at its own pace. It also tracks framing-error events and sticky overflow, so no byte or error is lost silently between the serial front end and the consumer.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `WIDTH`, 8: data width; matches receiver `rx_data`.
- `clk`  in  1  system clock; same clock as the receiver.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `rx_data`  in  WIDTH  byte from the receiver; valid whenever `rx_done` is high.
- `rx_done`  in  1  receiver done level; may stay high for many `clk` cycles (one baud tick).
- `rx_error`  in  1  receiver stop-bit error level; held until the next good frame.
- `rd_en`  in  1  pop request from the consumer.
- `rd_data`  out  WIDTH  popped byte; registered.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid this cycle.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `clr_ovf`  in  1  clears `overflow`.
- `frame_err_cnt`  out  8  saturating count of framing-error events.

## Operation
- **Edge detect:**
  - Register `rx_done_q` and `rx_error_q`.
  - `push = rx_done & ~rx_done_q`, so exactly one push per frame however long `rx_done` is held.
  - `err_evt = rx_error & ~rx_error_q`.
- **Push:** on `push`, write `rx_data` at `wr_ptr`, then `wr_ptr` increments modulo `DEPTH`.
- **Pop:** on `rd_en & ~empty`, load `rd_data` from `rd_ptr`, then `rd_ptr` increments modulo `DEPTH`. `rd_valid` is 1 the following cycle.
- **Pop when empty:** ignored. `rd_valid` stays 0 and `rd_data` holds its previous value.
- **Push when full, no pop:** byte dropped, pointers unchanged, `overflow` is set.
- **Push and pop in the same cycle:**
  - Both are performed.
  - If full, the push is accepted and `overflow` is not set.
  - If empty, only the push is performed, because the pop is ignored.
- **Count:** `count` is +1 on push only, −1 on pop only, unchanged when both or neither occur. `empty = (count==0)`, `full = (count==DEPTH)`.
- **Pointers:** `$clog2(DEPTH)` bits wide; wrap naturally.
- **Framing errors:**
  - `err_evt` increments `frame_err_cnt`, which saturates at 255.
  - Errored frames produce no push, since the receiver does not assert `rx_done` for them.
- **Overflow clear:** `clr_ovf` clears `overflow`. If `clr_ovf` and a new overflow occur in the same cycle, set wins.
- **Reset values** (`reset_n` low at a rising edge):
  - Pointers, `count`, `rd_data`, `rd_valid`, `overflow`, `frame_err_cnt`, `rx_done_q`, `rx_error_q` are all 0.
  - `empty` = 1, `full` = 0.
  - Memory contents are not reset.
- **Reset mid-operation:** all queued bytes are discarded. A `rx_done` already high when `reset_n` rises counts as one push on the first cycle.

## Timing
- **Push latency:** on `rx_done` rising at cycle N, the byte is written at the end of N. `count`/`empty` reflect it in cycle N+1.
- **Pop latency:** `rd_en` at cycle N gives `rd_valid` and `rd_data` in cycle N+1.
- **Status update:** `count`/`full` update in N+1.
- **Throughput:** one push and one pop per cycle maximum.
- **No bypass:** a byte pushed in cycle N is poppable from cycle N+1.
- **Outputs:** all are registered or derived from registered `count`; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package `uart_pkg`:**
  - `UART_DATA_W = 8`
  - `UART_RXFIFO_DEPTH = 16`
  - `ERR_CNT_W = 8`
- **Sub-module `sync_fifo`:** a generic single-clock FIFO parameterised by `WIDTH`/`DEPTH`, with push/pop, count, full/empty and registered read. `uart_rx_fifo` wraps it with the edge detectors, the overflow flag and the error counter.

## Test plan
- **Single byte:** reset, then `rx_done` high for 10 cycles with `rx_data`=0xA5, then `rd_en` one cycle → exactly one entry (`count`=1); `rd_valid` pulse with `rd_data`=0xA5; `empty`=1 afterwards.
- **Fill and overflow:**
  - Push 16 bytes 0x00..0x0F → `full`=1.
  - Push 0xFF → `overflow`=1, `count`=16.
  - Pop 16 → data 0x00..0x0F in order, 0xFF never appears.
  - `clr_ovf` → `overflow`=0.
- **Simultaneous push/pop when full:** push 0x55 with `rd_en` high → pops the oldest byte, `count` stays 16, `overflow`=0, and 0x55 is the last byte read.
- **Pop when empty:** `rd_en` high for 3 cycles after reset → `rd_valid`=0 and `count`=0 throughout.
- **Framing errors:** 3 rising edges of `rx_error`, then 300 more → `frame_err_cnt`=3, then saturates at 255; `count` is unchanged.
- **Wrap and reset:**
  - Push/pop 40 bytes with interleaved timing → order preserved across pointer wrap.
  - Assert `reset_n`=0 with 5 entries queued → next cycle `count`=0, `empty`=1, `frame_err_cnt`=0.
